sat_sequencer: RTL and testbench

//  Run controller directly upstream of the SAT clause/CNF enable decoder; drives its 2-bit stateVal.

---
 rtl/sat_pkg.sv | 38 +++
 rtl/sat_idx_counter.sv | 30 +++
 rtl/sat_sequencer.sv | 121 ++++++++++++
 tb/tb_sat_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared SAT encodings: stateVal codes understood by the clause/CNF enable decoder,
// plus the sequencer FSM state enum and small decode helpers.
package sat_pkg;

   localparam int CLAUSE_W_DEF = 8;
   localparam int LIT_W_DEF    = 4;

   typedef enum logic [1:0] {
      RESET_SAT      = 2'b00,
      COMPUTE_CLAUSE = 2'b01,
      COMPUTE_CNF    = 2'b10,
      RESET_CLAUSE   = 2'b11
   } state_val_t;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_INIT,
      SEQ_CLAUSE,
      SEQ_CNF,
      SEQ_RCLR,
      SEQ_DONE
   } seq_state_t;

   // DONE keeps RESET_CLAUSE's code so the decoder leaves the CNF result untouched.
   function automatic state_val_t state_val_of(input seq_state_t s);
      case (s)
         SEQ_CLAUSE:         return COMPUTE_CLAUSE;
         SEQ_CNF:            return COMPUTE_CNF;
         SEQ_RCLR, SEQ_DONE: return RESET_CLAUSE;
         default:            return RESET_SAT;
      endcase
   endfunction

   function automatic logic is_busy(input seq_state_t s);
      return (s == SEQ_INIT) || (s == SEQ_CLAUSE) || (s == SEQ_CNF) || (s == SEQ_RCLR);
   endfunction

endpackage

// File: rtl/sat_idx_counter.sv
// Clear/increment index counter with a terminal-compare flag; holds at the terminal
// value instead of wrapping.
module sat_idx_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] term,
   output logic [W-1:0] count,
   output logic         at_term
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && !at_term) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign count   = count_reg;
   assign at_term = (count_reg == term);

endmodule

// File: rtl/sat_sequencer.sv
// SAT run sequencer: INIT, then per clause L literal cycles, one CNF cycle and one clause clear.
// Optional SAT_SEQ_STALL_EN adds a stall input that freezes an active run.
module sat_sequencer
   import sat_pkg::*;
#(
   parameter int CLAUSE_W = CLAUSE_W_DEF,
   parameter int LIT_W    = LIT_W_DEF
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic                start,
   input  logic                abort,
   input  logic [CLAUSE_W-1:0] num_clauses,
   input  logic [LIT_W-1:0]    lits_per_clause,
   output logic [1:0]          stateVal,
   output logic [CLAUSE_W-1:0] clause_idx,
   output logic [LIT_W-1:0]    lit_idx,
   output logic                busy,
   output logic                done,
   output logic                cfg_err
`ifdef SAT_SEQ_STALL_EN
   ,input logic                stall
`endif
);

   seq_state_t          state_reg, state_next;
   state_val_t          state_val_reg, state_val_next;
   logic                busy_reg, busy_next;
   logic                done_reg, done_next;
   logic                cfg_err_reg, cfg_err_next;
   logic [CLAUSE_W-1:0] n_reg;
   logic [LIT_W-1:0]    l_reg;

   logic idle_like, cfg_ok, start_accept, stall_eff;
   logic clause_last, lit_last;
   logic clause_clr, clause_inc, lit_clr, lit_inc;

   assign idle_like    = (state_reg == SEQ_IDLE) || (state_reg == SEQ_DONE);
   assign cfg_ok       = (num_clauses != '0) && (lits_per_clause != '0);
   assign start_accept = idle_like && start && !abort && cfg_ok;

`ifdef SAT_SEQ_STALL_EN
   assign stall_eff = stall && is_busy(state_reg);
`else
   assign stall_eff = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_reg     <= SEQ_IDLE;
         state_val_reg <= RESET_SAT;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         cfg_err_reg   <= 1'b0;
         n_reg         <= '0;
         l_reg         <= '0;
      end else begin
         state_reg     <= state_next;
         state_val_reg <= state_val_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         cfg_err_reg   <= cfg_err_next;
         if (start_accept) begin
            n_reg <= num_clauses;
            l_reg <= lits_per_clause;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         SEQ_IDLE, SEQ_DONE: if (start_accept) state_next = SEQ_INIT;
         SEQ_INIT:           state_next = SEQ_CLAUSE;
         SEQ_CLAUSE:         if (lit_last) state_next = SEQ_CNF;
         SEQ_CNF:            state_next = SEQ_RCLR;
         SEQ_RCLR:           state_next = clause_last ? SEQ_DONE : SEQ_CLAUSE;
         default:            state_next = SEQ_IDLE;
      endcase
      if (stall_eff) state_next = state_reg;
      if (abort)     state_next = SEQ_IDLE;
   end

   // Outputs are decoded from the next state so the registered copies line up with state_reg.
   always_comb begin
      state_val_next = state_val_of(state_next);
      busy_next      = is_busy(state_next);
      done_next      = (state_next == SEQ_DONE);
      cfg_err_next   = idle_like && start && !abort && !cfg_ok;
      clause_clr     = (state_next == SEQ_IDLE) || (state_next == SEQ_INIT);
      clause_inc     = (state_reg == SEQ_RCLR) && (state_next == SEQ_CLAUSE);
      lit_clr        = (state_next != SEQ_CLAUSE);
      lit_inc        = (state_reg == SEQ_CLAUSE) && !stall_eff && !lit_last;
   end

   sat_idx_counter #(.W(CLAUSE_W)) u_clause_cnt (
      .clk     (clk),
      .resetN  (resetN),
      .clr     (clause_clr),
      .inc     (clause_inc),
      .term    (n_reg - CLAUSE_W'(1)),
      .count   (clause_idx),
      .at_term (clause_last)
   );

   sat_idx_counter #(.W(LIT_W)) u_lit_cnt (
      .clk     (clk),
      .resetN  (resetN),
      .clr     (lit_clr),
      .inc     (lit_inc),
      .term    (l_reg - LIT_W'(1)),
      .count   (lit_idx),
      .at_term (lit_last)
   );

   assign stateVal = state_val_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign cfg_err  = cfg_err_reg;

endmodule

// File: tb/tb_sat_sequencer.sv
// Directed bench for sat_sequencer: cycle-by-cycle vector table plus hand-written
// sequences for async reset and (with SAT_SEQ_STALL_EN) stall.
module tb_sat_sequencer;

   logic       clk = 1'b0;
   logic       resetN;
   logic       start;
   logic       abort;
   logic [7:0] num_clauses;
   logic [3:0] lits_per_clause;
   logic [1:0] stateVal;
   logic [7:0] clause_idx;
   logic [3:0] lit_idx;
   logic       busy;
   logic       done;
   logic       cfg_err;
`ifdef SAT_SEQ_STALL_EN
   logic       stall;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       st;
      logic       ab;
      logic [7:0] nc;
      logic [3:0] lpc;
      logic [1:0] sv;
      logic [7:0] ci;
      logic [3:0] li;
      logic       b;
      logic       d;
      logic       ce;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   sat_sequencer #(.CLAUSE_W(8), .LIT_W(4)) dut (
      .clk             (clk),
      .resetN          (resetN),
      .start           (start),
      .abort           (abort),
      .num_clauses     (num_clauses),
      .lits_per_clause (lits_per_clause),
      .stateVal        (stateVal),
      .clause_idx      (clause_idx),
      .lit_idx         (lit_idx),
      .busy            (busy),
      .done            (done),
      .cfg_err         (cfg_err)
`ifdef SAT_SEQ_STALL_EN
      ,.stall          (stall)
`endif
   );

   task automatic add(input logic st, input logic ab, input logic [7:0] nc, input logic [3:0] lpc,
                      input logic [1:0] sv, input logic [7:0] ci, input logic [3:0] li,
                      input logic b, input logic d, input logic ce);
      vec_t v;
      v.st = st; v.ab = ab; v.nc = nc; v.lpc = lpc;
      v.sv = sv; v.ci = ci; v.li = li; v.b = b; v.d = d; v.ce = ce;
      vecs.push_back(v);
   endtask

   task automatic step(input logic st, input logic ab, input logic [7:0] nc, input logic [3:0] lpc);
      @(negedge clk);
      start           = st;
      abort           = ab;
      num_clauses     = nc;
      lits_per_clause = lpc;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [1:0] sv, input logic [7:0] ci, input logic [3:0] li,
                      input logic b, input logic d, input logic ce);
      logic [16:0] got, req;
      got = {stateVal, clause_idx, lit_idx, busy, done, cfg_err};
      req = {sv, ci, li, b, d, ce};
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got sv=%b ci=%0d li=%0d busy=%b done=%b cfg_err=%b, required sv=%b ci=%0d li=%0d busy=%b done=%b cfg_err=%b",
                  name, stateVal, clause_idx, lit_idx, busy, done, cfg_err, sv, ci, li, b, d, ce);
      end else begin
         $display("%s: sv=%b ci=%0d li=%0d busy=%b done=%b cfg_err=%b", name,
                  stateVal, clause_idx, lit_idx, busy, done, cfg_err);
      end
   endtask

   initial begin
      resetN = 1'b0; start = 1'b0; abort = 1'b0; num_clauses = '0; lits_per_clause = '0;
`ifdef SAT_SEQ_STALL_EN
      stall = 1'b0;
`endif
      // N=3, L=2; inputs change mid-run and a start arrives during CNF, both ignored
      add(1,0,3,2, 2'b00,0,0,1,0,0);
      add(0,0,7,9, 2'b01,0,0,1,0,0); add(0,0,7,9, 2'b01,0,1,1,0,0);
      add(0,0,7,9, 2'b10,0,0,1,0,0); add(0,0,7,9, 2'b11,0,0,1,0,0);
      add(0,0,7,9, 2'b01,1,0,1,0,0); add(0,0,7,9, 2'b01,1,1,1,0,0);
      add(1,0,1,1, 2'b10,1,0,1,0,0); add(0,0,7,9, 2'b11,1,0,1,0,0);
      add(0,0,7,9, 2'b01,2,0,1,0,0); add(0,0,7,9, 2'b01,2,1,1,0,0);
      add(0,0,7,9, 2'b10,2,0,1,0,0); add(0,0,7,9, 2'b11,2,0,1,0,0);
      add(0,0,0,0, 2'b11,2,0,0,1,0); add(0,0,0,0, 2'b11,2,0,0,1,0);
      // restart from DONE with N=1, L=1
      add(1,0,1,1, 2'b00,0,0,1,0,0); add(0,0,0,0, 2'b01,0,0,1,0,0);
      add(0,0,0,0, 2'b10,0,0,1,0,0); add(0,0,0,0, 2'b11,0,0,1,0,0);
      add(0,0,0,0, 2'b11,0,0,0,1,0); add(0,0,0,0, 2'b11,0,0,0,1,0);
      // abort from DONE, rejected configs, start+abort together
      add(0,1,0,0, 2'b00,0,0,0,0,0);
      add(1,0,0,4, 2'b00,0,0,0,0,1); add(0,0,0,4, 2'b00,0,0,0,0,0);
      add(1,0,5,0, 2'b00,0,0,0,0,1); add(0,0,5,0, 2'b00,0,0,0,0,0);
      add(1,1,2,2, 2'b00,0,0,0,0,0); add(0,0,2,2, 2'b00,0,0,0,0,0);
      // N=4, L=3, abort on 2nd literal cycle of clause 1
      add(1,0,4,3, 2'b00,0,0,1,0,0);
      add(0,0,4,3, 2'b01,0,0,1,0,0); add(0,0,4,3, 2'b01,0,1,1,0,0); add(0,0,4,3, 2'b01,0,2,1,0,0);
      add(0,0,4,3, 2'b10,0,0,1,0,0); add(0,0,4,3, 2'b11,0,0,1,0,0);
      add(0,0,4,3, 2'b01,1,0,1,0,0); add(0,0,4,3, 2'b01,1,1,1,0,0);
      add(0,1,4,3, 2'b00,0,0,0,0,0); add(0,0,4,3, 2'b00,0,0,0,0,0);

      #12;
      chk("reset", 2'b00, 0, 0, 0, 0, 0);
      @(negedge clk);
      resetN = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].st, vecs[i].ab, vecs[i].nc, vecs[i].lpc);
         chk($sformatf("vec%0d", i), vecs[i].sv, vecs[i].ci, vecs[i].li, vecs[i].b, vecs[i].d, vecs[i].ce);
      end

      // asynchronous reset in the middle of clause 1
      step(1,0,2,2); chk("ar_init", 2'b00, 0, 0, 1, 0, 0);
      step(0,0,2,2); step(0,0,2,2); step(0,0,2,2); step(0,0,2,2);
      step(0,0,2,2); chk("ar_pre", 2'b01, 1, 0, 1, 0, 0);
      #2;
      resetN = 1'b0;
      #1;
      chk("ar_async", 2'b00, 0, 0, 0, 0, 0);
      @(negedge clk);
      resetN = 1'b1;
      step(0,0,2,2); chk("ar_idle", 2'b00, 0, 0, 0, 0, 0);

`ifdef SAT_SEQ_STALL_EN
      begin
         int cnt;
         int guard;
         step(1,0,2,3); chk("st_init", 2'b00, 0, 0, 1, 0, 0);
         step(0,0,2,3); chk("st_l0", 2'b01, 0, 0, 1, 0, 0);
         step(0,0,2,3); chk("st_l1", 2'b01, 0, 1, 1, 0, 0);
         stall = 1'b1;
         for (int k = 0; k < 3; k++) begin
            step(0,0,2,3); chk($sformatf("st_hold%0d", k), 2'b01, 0, 1, 1, 0, 0);
         end
         stall = 1'b0;
         cnt = 6;
         guard = 0;
         while (!done && guard < 100) begin
            step(0,0,2,3);
            guard++;
            if (busy) cnt++;
         end
         chk("st_done", 2'b11, 1, 0, 0, 1, 0);
         checks++;
         if (cnt != 14) begin
            errors++;
            $display("FAIL st_len: got %0d busy cycles, required 14", cnt);
         end else begin
            $display("st_len: %0d busy cycles", cnt);
         end
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
